keypad_conditioner: RTL and testbench

- Input-conditioning stage directly upstream of the microwave top.
- Synchronises and debounces the raw 10-key numeric keypad, the start/stop/clear pushbuttons and the door switch.
- Converts each accepted key press into a single-cycle one-hot pulse plus a binary code, feeding the time-entry/control stage.
- Delivers clean active-low button levels and a clean door level to the magnetron control stage.

---
 rtl/keypad_conditioner.sv | 164 ++++++++++++++++
 tb/tb_keypad_conditioner.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_conditioner.sv
// Input conditioning for the microwave front panel: synchronises and debounces keypad,
// buttons and door switch, and turns each accepted key press into a one-cycle strobe.
module keypad_conditioner #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int CNT_W           = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] keypad_raw,
    input  logic       startn_raw,
    input  logic       stopn_raw,
    input  logic       clearn_raw,
    input  logic       door_raw,
    output logic [9:0] keypad,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_err,
    output logic       startn,
    output logic       stopn,
    output logic       clearn,
    output logic       door_closed
);

    localparam int N_IN = 14;
    // Idle levels: keys released, buttons released (high), door open (safe)
    localparam logic [N_IN-1:0] RST_VAL_C  = {1'b0, 1'b1, 1'b1, 1'b1, 10'b0000000000};
    localparam logic [CNT_W-1:0] CNT_LAST_C = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    logic [N_IN-1:0]  raw_s;
    logic [N_IN-1:0]  meta_r;
    logic [N_IN-1:0]  sync_r;
    logic [N_IN-1:0]  deb_r;
    logic [CNT_W-1:0] cnt_r [N_IN];
    logic [9:0]       key_s;

    state_t     state_r, state_s;
    logic [9:0] keypad_r, keypad_s;
    logic [3:0] key_code_r, key_code_s;
    logic       key_valid_r, key_valid_s;
    logic       key_err_r, key_err_s;

    function automatic logic is_one_hot(input logic [9:0] k);
        return (k != 10'd0) && ((k & (k - 10'd1)) == 10'd0);
    endfunction

    function automatic logic [3:0] encode_key(input logic [9:0] k);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) begin
                code = 4'(i);
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

    assign raw_s = {door_raw, clearn_raw, stopn_raw, startn_raw, keypad_raw};
    assign key_s = deb_r[9:0];

    // Two-flop synchroniser for every raw input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= RST_VAL_C;
            sync_r <= RST_VAL_C;
        end else begin
            meta_r <= raw_s;
            sync_r <= meta_r;
        end
    end

    // Per-input debounce: flip only after DEBOUNCE_CYCLES consecutive mismatches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_r <= RST_VAL_C;
            for (int i = 0; i < N_IN; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync_r[i] == deb_r[i]) begin
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else if (cnt_r[i] == CNT_LAST_C) begin
                    deb_r[i] <= ~deb_r[i];
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE_C;
                end
            end
        end
    end

    // Key FSM next-state and next-output logic; key_code holds between strobes
    always_comb begin
        state_s     = state_r;
        keypad_s    = 10'd0;
        key_code_s  = key_code_r;
        key_valid_s = 1'b0;
        key_err_s   = key_err_r;
        case (state_r)
            IDLE: begin
                if (key_s == 10'd0) begin
                    key_err_s = 1'b0;
                end else if (is_one_hot(key_s)) begin
                    keypad_s    = key_s;
                    key_code_s  = encode_key(key_s);
                    key_valid_s = 1'b1;
                    state_s     = HELD;
                end else begin
                    key_err_s = 1'b1;
                    state_s   = HELD;
                end
            end
            HELD: begin
                if (key_s == 10'd0) begin
                    key_err_s = 1'b0;
                    state_s   = IDLE;
                end else if (!is_one_hot(key_s)) begin
                    key_err_s = 1'b1;
                end else begin
                    key_err_s = key_err_r;
                end
            end
            default: begin
                state_s   = IDLE;
                key_err_s = 1'b0;
            end
        endcase
    end

    // Key FSM state and registered key outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            keypad_r    <= 10'd0;
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            keypad_r    <= keypad_s;
            key_code_r  <= key_code_s;
            key_valid_r <= key_valid_s;
            key_err_r   <= key_err_s;
        end
    end

    assign keypad      = keypad_r;
    assign key_code    = key_code_r;
    assign key_valid   = key_valid_r;
    assign key_err     = key_err_r;
    assign startn      = deb_r[10];
    assign stopn       = deb_r[11];
    assign clearn      = deb_r[12];
    assign door_closed = deb_r[13];

endmodule

// File: tb/tb_keypad_conditioner.sv
// Scoreboard bench for keypad_conditioner: stimulus queues expected output events with
// their cycle stamps; an independent monitor detects every output event and compares.
module tb_keypad_conditioner;

    localparam int D       = 4;
    localparam int K_KEY   = 0;
    localparam int K_ERR   = 1;
    localparam int K_START = 2;
    localparam int K_STOP  = 3;
    localparam int K_CLEAR = 4;
    localparam int K_DOOR  = 5;

    logic       clk;
    logic       reset;
    logic [9:0] keypad_raw;
    logic       startn_raw, stopn_raw, clearn_raw, door_raw;
    logic [9:0] keypad;
    logic [3:0] key_code;
    logic       key_valid, key_err, startn, stopn, clearn, door_closed;

    keypad_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .keypad_raw(keypad_raw),
        .startn_raw(startn_raw), .stopn_raw(stopn_raw), .clearn_raw(clearn_raw),
        .door_raw(door_raw), .keypad(keypad), .key_code(key_code),
        .key_valid(key_valid), .key_err(key_err), .startn(startn), .stopn(stopn),
        .clearn(clearn), .door_closed(door_closed)
    );

    typedef struct {
        int          kind;
        logic [13:0] val;
        int          at;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    bit  mon_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_KEY:   return "key_pulse";
            K_ERR:   return "key_err";
            K_START: return "startn";
            K_STOP:  return "stopn";
            K_CLEAR: return "clearn";
            K_DOOR:  return "door_closed";
            default: return "unknown";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input logic [13:0] val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input int kind, input logic [13:0] val);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: unexpected event val=%h at cyc %0d, no event expected",
                     kname(kind), val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val || e.at != cyc) begin
                miscompares++;
                $display("FAIL %s: got %s val=%h at cyc %0d, expected %s val=%h at cyc %0d",
                         kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.at);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [13:0] got, input logic [13:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, " keypad"},      {4'd0, keypad},       14'd0);
        check_val({tag, " key_code"},    {10'd0, key_code},    14'd0);
        check_val({tag, " key_valid"},   {13'd0, key_valid},   14'd0);
        check_val({tag, " key_err"},     {13'd0, key_err},     14'd0);
        check_val({tag, " startn"},      {13'd0, startn},      14'd1);
        check_val({tag, " stopn"},       {13'd0, stopn},       14'd1);
        check_val({tag, " clearn"},      {13'd0, clearn},      14'd1);
        check_val({tag, " door_closed"}, {13'd0, door_closed}, 14'd0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int kind, input logic v);
        case (kind)
            K_START: startn_raw = v;
            K_STOP:  stopn_raw  = v;
            K_CLEAR: clearn_raw = v;
            K_DOOR:  door_raw   = v;
            default: ;
        endcase
    endtask

    // Bounce v,~v,v,~v then hold v: the level flips 2+D edges after the steady drive.
    task automatic bounce_to(input int kind, input logic v);
        set_btn(kind, v);  cycles(1);
        set_btn(kind, ~v); cycles(1);
        set_btn(kind, v);  cycles(1);
        set_btn(kind, ~v); cycles(1);
        set_btn(kind, v);
        expect_ev(kind, {13'd0, v}, cyc + 2 + D);
        cycles(12);
    endtask

    task automatic settle(input int kind, input logic v);
        set_btn(kind, v);
        expect_ev(kind, {13'd0, v}, cyc + 2 + D);
        cycles(12);
    endtask

    // Monitor: any change on a level output or any key strobe is an event
    initial begin
        logic p_err, p_start, p_stop, p_clear, p_door;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                if (key_valid || keypad != 10'd0) got_ev(K_KEY, {key_code, keypad});
                if (key_err !== p_err)         got_ev(K_ERR,   {13'd0, key_err});
                if (startn !== p_start)        got_ev(K_START, {13'd0, startn});
                if (stopn !== p_stop)          got_ev(K_STOP,  {13'd0, stopn});
                if (clearn !== p_clear)        got_ev(K_CLEAR, {13'd0, clearn});
                if (door_closed !== p_door)    got_ev(K_DOOR,  {13'd0, door_closed});
            end
            p_err   = key_err;
            p_start = startn;
            p_stop  = stopn;
            p_clear = clearn;
            p_door  = door_closed;
        end
    end

    initial begin
        reset = 1'b1;
        keypad_raw = 10'd0;
        startn_raw = 1'b1;
        stopn_raw  = 1'b1;
        clearn_raw = 1'b1;
        door_raw   = 1'b0;
        cycles(2);
        check_reset_outputs("por");
        reset  = 1'b0;
        mon_en = 1'b1;
        cycles(3);

        // Single key 3 held: one pulse 3+D edges later, nothing more while held
        keypad_raw = 10'b0000001000;
        expect_ev(K_KEY, {4'd3, 10'b0000001000}, cyc + 3 + D);
        cycles(20);
        keypad_raw = 10'd0;
        cycles(10);

        // 3-cycle glitch on key 5: no event at all
        keypad_raw = 10'b0000100000;
        cycles(3);
        keypad_raw = 10'd0;
        cycles(10);

        // Key 2 held, key 7 added, both released
        keypad_raw = 10'b0000000100;
        expect_ev(K_KEY, {4'd2, 10'b0000000100}, cyc + 3 + D);
        cycles(10);
        keypad_raw = 10'b0010000100;
        expect_ev(K_ERR, 14'd1, cyc + 3 + D);
        cycles(10);
        keypad_raw = 10'd0;
        expect_ev(K_ERR, 14'd0, cyc + 3 + D);
        cycles(10);

        // Chord 1+4 from IDLE, release, then key 9
        keypad_raw = 10'b0000010010;
        expect_ev(K_ERR, 14'd1, cyc + 3 + D);
        cycles(10);
        keypad_raw = 10'd0;
        expect_ev(K_ERR, 14'd0, cyc + 3 + D);
        cycles(10);
        keypad_raw = 10'b1000000000;
        expect_ev(K_KEY, {4'd9, 10'b1000000000}, cyc + 3 + D);
        cycles(10);
        keypad_raw = 10'd0;
        cycles(10);

        // Bouncing buttons and door
        bounce_to(K_START, 1'b0);
        settle(K_START, 1'b1);
        bounce_to(K_STOP, 1'b0);
        settle(K_STOP, 1'b1);
        bounce_to(K_CLEAR, 1'b0);
        settle(K_CLEAR, 1'b1);
        bounce_to(K_DOOR, 1'b1);
        settle(K_DOOR, 1'b0);

        // Simultaneous stop and clear change independently
        stopn_raw  = 1'b0;
        clearn_raw = 1'b0;
        expect_ev(K_STOP,  14'd0, cyc + 2 + D);
        expect_ev(K_CLEAR, 14'd0, cyc + 2 + D);
        cycles(12);
        stopn_raw  = 1'b1;
        clearn_raw = 1'b1;
        expect_ev(K_STOP,  14'd1, cyc + 2 + D);
        expect_ev(K_CLEAR, 14'd1, cyc + 2 + D);
        cycles(12);

        // Async reset with start held low and key 6 mid-debounce (counter = 2)
        startn_raw = 1'b0;
        expect_ev(K_START, 14'd0, cyc + 2 + D);
        cycles(12);
        keypad_raw = 10'b0001000000;
        cycles(4);
        mon_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async");
        cycles(3);
        reset  = 1'b0;
        mon_en = 1'b1;
        expect_ev(K_START, 14'd0, cyc + 2 + D);
        expect_ev(K_KEY, {4'd6, 10'b0001000000}, cyc + 3 + D);
        cycles(12);
        keypad_raw = 10'd0;
        startn_raw = 1'b1;
        expect_ev(K_START, 14'd1, cyc + 2 + D);
        cycles(12);

        cycles(5);
        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: event never seen, expected val=%h at cyc %0d",
                     kname(e.kind), e.val, e.at);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
